// File: rtl/gameplay_control_n.sv
// Tower-game gameplay controller: turns key presses and the overlap flag into
// datapath load/move/retry strobes, and keeps the row, chance and score counters.
module gameplay_control_n #(
    parameter int NUM_ROWS     = 7,
    parameter int ROW_HEIGHT   = 16,
    parameter int Y_BASE       = 104,
    parameter int Y_W          = 7,
    parameter int CHANCE_W     = 3,
    parameter int INIT_CHANCES = 3,
    parameter int SCORE_W      = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          s,
    input  logic                          p,
    input  logic                          o,
    output logic                          ld_y,
    output logic [Y_W-1:0]                new_y,
    output logic                          enable,
    output logic                          move_on,
    output logic                          go_back,
    output logic                          inc_score,
    output logic                          dec_chances,
    output logic [1:0]                    game_status,
    output logic [$clog2(NUM_ROWS)-1:0]   row,
    output logic [CHANCE_W-1:0]           chances,
    output logic [SCORE_W-1:0]            score
);
    localparam int ROW_W = $clog2(NUM_ROWS);

    localparam logic [1:0] ST_PAUSED  = 2'b00;
    localparam logic [1:0] ST_PLAYING = 2'b01;
    localparam logic [1:0] ST_WIN     = 2'b10;
    localparam logic [1:0] ST_LOSE    = 2'b11;

    typedef enum logic [1:0] {S_LOAD, S_PLAY, S_WIN, S_LOSE} state_t;

    state_t               state_q, state_d;
    logic                 s_q;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [CHANCE_W-1:0]  chances_q, chances_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [Y_W-1:0]       new_y_q, new_y_d;
    logic [1:0]           status_q, status_d;
    logic                 ld_y_q, ld_y_d, move_on_q, move_on_d, go_back_q, go_back_d;
    logic                 inc_q, inc_d, dec_q, dec_d, enable_q, enable_d;
    logic                 press;

    // s_q resets high so a key held through reset is not seen as a press.
    assign press = s & ~s_q;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        chances_d = chances_q;
        score_d   = score_q;
        status_d  = status_q;
        ld_y_d    = 1'b0;
        move_on_d = 1'b0;
        go_back_d = 1'b0;
        inc_d     = 1'b0;
        dec_d     = 1'b0;
        enable_d  = 1'b0;
        case (state_q)
            S_LOAD: begin
                state_d  = S_PLAY;
                enable_d = ~p;
                status_d = p ? ST_PAUSED : ST_PLAYING;
            end
            S_PLAY: begin
                enable_d = ~p;
                status_d = p ? ST_PAUSED : ST_PLAYING;
                // A press during pause is dropped rather than queued.
                if (press && !p) begin
                    enable_d = 1'b0;
                    if (o) begin
                        inc_d   = 1'b1;
                        score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
                        if (row_q == ROW_W'(NUM_ROWS - 1)) begin
                            state_d  = S_WIN;
                            status_d = ST_WIN;
                        end else begin
                            row_d     = row_q + ROW_W'(1);
                            state_d   = S_LOAD;
                            ld_y_d    = 1'b1;
                            move_on_d = 1'b1;
                        end
                    end else begin
                        dec_d     = 1'b1;
                        go_back_d = 1'b1;
                        if (chances_q == CHANCE_W'(1)) begin
                            chances_d = '0;
                            state_d   = S_LOSE;
                            status_d  = ST_LOSE;
                        end else begin
                            chances_d = chances_q - CHANCE_W'(1);
                            state_d   = S_LOAD;
                            ld_y_d    = 1'b1;
                        end
                    end
                end
            end
            S_WIN, S_LOSE: begin
                status_d = (state_q == S_WIN) ? ST_WIN : ST_LOSE;
                if (press) begin
                    row_d     = '0;
                    score_d   = '0;
                    chances_d = CHANCE_W'(INIT_CHANCES);
                    state_d   = S_LOAD;
                    status_d  = ST_PLAYING;
                    ld_y_d    = 1'b1;
                    move_on_d = 1'b1;
                end
            end
            default: begin
                state_d  = S_LOAD;
                row_d    = '0;
                ld_y_d   = 1'b1;
                status_d = ST_PLAYING;
            end
        endcase
        new_y_d = Y_W'(Y_BASE - int'(row_d) * ROW_HEIGHT);
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q   <= S_LOAD;
            s_q       <= 1'b1;
            row_q     <= '0;
            chances_q <= CHANCE_W'(INIT_CHANCES);
            score_q   <= '0;
            new_y_q   <= Y_W'(Y_BASE);
            status_q  <= ST_PLAYING;
            ld_y_q    <= 1'b1;
            move_on_q <= 1'b1;
            go_back_q <= 1'b0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            enable_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s;
            row_q     <= row_d;
            chances_q <= chances_d;
            score_q   <= score_d;
            new_y_q   <= new_y_d;
            status_q  <= status_d;
            ld_y_q    <= ld_y_d;
            move_on_q <= move_on_d;
            go_back_q <= go_back_d;
            inc_q     <= inc_d;
            dec_q     <= dec_d;
            enable_q  <= enable_d;
        end
    end

    assign ld_y        = ld_y_q;
    assign new_y       = new_y_q;
    assign enable      = enable_q;
    assign move_on     = move_on_q;
    assign go_back     = go_back_q;
    assign inc_score   = inc_q;
    assign dec_chances = dec_q;
    assign game_status = status_q;
    assign row         = row_q;
    assign chances     = chances_q;
    assign score       = score_q;
endmodule

// File: tb/tb_gameplay_control_n.sv
// Directed bench for gameplay_control_n: per-cycle vector table plus
// hand-written sequences for held keys and mid-flight reset.
module tb_gameplay_control_n;
    logic clk = 1'b0;
    logic resetn, s, p, o;
    logic ld_y, enable, move_on, go_back, inc_score, dec_chances;
    logic [6:0] new_y;
    logic [1:0] game_status;
    logic [2:0] row, chances;
    logic [7:0] score;

    gameplay_control_n dut (
        .clk(clk), .resetn(resetn), .s(s), .p(p), .o(o),
        .ld_y(ld_y), .new_y(new_y), .enable(enable), .move_on(move_on),
        .go_back(go_back), .inc_score(inc_score), .dec_chances(dec_chances),
        .game_status(game_status), .row(row), .chances(chances), .score(score)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic ld, mv, gb, inc, dec, en;
        logic [1:0] st;
        logic [2:0] row;
        logic [2:0] ch;
        logic [7:0] sc;
        logic [6:0] y;
    } out_t;

    typedef struct {
        logic s, p, o;
        out_t e;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int failures = 0;

    function automatic vec_t v(input logic vs, vp, vo, ld, mv, gb, inc, dec, en,
                               input logic [1:0] st, input int r, ch, sc, y);
        vec_t t;
        t.s = vs; t.p = vp; t.o = vo;
        t.e = '{ld, mv, gb, inc, dec, en, st, 3'(r), 3'(ch), 8'(sc), 7'(y)};
        return t;
    endfunction

    function automatic out_t sample();
        return '{ld_y, move_on, go_back, inc_score, dec_chances, enable,
                 game_status, row, chances, score, new_y};
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t got;
        got = sample();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got ld=%b mv=%b gb=%b inc=%b dec=%b en=%b st=%b row=%0d ch=%0d sc=%0d y=%0d want ld=%b mv=%b gb=%b inc=%b dec=%b en=%b st=%b row=%0d ch=%0d sc=%0d y=%0d",
                     name, got.ld, got.mv, got.gb, got.inc, got.dec, got.en, got.st, got.row, got.ch, got.sc, got.y,
                     exp.ld, exp.mv, exp.gb, exp.inc, exp.dec, exp.en, exp.st, exp.row, exp.ch, exp.sc, exp.y);
        end
    endtask

    task automatic step(input logic vs, vp, vo);
        s = vs; p = vp; o = vo;
        @(posedge clk);
        #1;
    endtask

    out_t rst_vals;
    int inc_cnt;

    initial begin
        rst_vals = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'd0, 3'd3, 8'd0, 7'd104};

        // Win run: held key through reset, then 7 good placements.
        tbl.push_back(v(1,0,1, 0,0,0,0,0,1, 2'b01, 0,3,0,104));
        tbl.push_back(v(0,0,1, 0,0,0,0,0,1, 2'b01, 0,3,0,104));
        for (int k = 1; k <= 6; k++) begin
            tbl.push_back(v(1,0,1, 1,1,0,1,0,0, 2'b01, k,3,k,104-16*k));
            tbl.push_back(v(0,0,1, 0,0,0,0,0,1, 2'b01, k,3,k,104-16*k));
        end
        tbl.push_back(v(1,0,1, 0,0,0,1,0,0, 2'b10, 6,3,7,8));
        tbl.push_back(v(0,0,1, 0,0,0,0,0,0, 2'b10, 6,3,7,8));
        tbl.push_back(v(1,0,1, 1,1,0,0,0,0, 2'b01, 0,3,0,104));
        tbl.push_back(v(0,0,1, 0,0,0,0,0,1, 2'b01, 0,3,0,104));
        // Lose run at row 2.
        for (int k = 1; k <= 2; k++) begin
            tbl.push_back(v(1,0,1, 1,1,0,1,0,0, 2'b01, k,3,k,104-16*k));
            tbl.push_back(v(0,0,1, 0,0,0,0,0,1, 2'b01, k,3,k,104-16*k));
        end
        tbl.push_back(v(1,0,0, 1,0,1,0,1,0, 2'b01, 2,2,2,72));
        tbl.push_back(v(0,0,0, 0,0,0,0,0,1, 2'b01, 2,2,2,72));
        tbl.push_back(v(1,0,0, 1,0,1,0,1,0, 2'b01, 2,1,2,72));
        tbl.push_back(v(0,0,0, 0,0,0,0,0,1, 2'b01, 2,1,2,72));
        tbl.push_back(v(1,0,0, 0,0,1,0,1,0, 2'b11, 2,0,2,72));
        tbl.push_back(v(0,0,0, 0,0,0,0,0,0, 2'b11, 2,0,2,72));
        // Restart from LOSE with p high: p ignored there.
        tbl.push_back(v(1,1,1, 1,1,0,0,0,0, 2'b01, 0,3,0,104));
        tbl.push_back(v(0,0,1, 0,0,0,0,0,1, 2'b01, 0,3,0,104));
        // Pause: presses ignored and not queued.
        tbl.push_back(v(0,1,1, 0,0,0,0,0,0, 2'b00, 0,3,0,104));
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(v(1,1,1, 0,0,0,0,0,0, 2'b00, 0,3,0,104));
            tbl.push_back(v(0,1,1, 0,0,0,0,0,0, 2'b00, 0,3,0,104));
        end
        tbl.push_back(v(0,0,1, 0,0,0,0,0,1, 2'b01, 0,3,0,104));
        tbl.push_back(v(1,1,1, 0,0,0,0,0,0, 2'b00, 0,3,0,104));
        tbl.push_back(v(1,0,1, 0,0,0,0,0,1, 2'b01, 0,3,0,104));
        tbl.push_back(v(0,0,1, 0,0,0,0,0,1, 2'b01, 0,3,0,104));

        resetn = 1'b1; s = 1'b1; p = 1'b0; o = 1'b1;
        #12;
        check("reset_state", rst_vals);
        @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("after_release", rst_vals);

        foreach (tbl[i]) begin
            step(tbl[i].s, tbl[i].p, tbl[i].o);
            check($sformatf("vec%0d", i), tbl[i].e);
        end

        // Key held for 20 cycles: exactly one placement.
        inc_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            step(1, 0, 1);
            if (inc_score === 1'b1) inc_cnt++;
        end
        checks++;
        if (inc_cnt != 1) begin
            failures++;
            $display("FAIL held_key inc pulses got=%0d want=1", inc_cnt);
        end
        step(0, 0, 1);
        check("held_key_after", '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b01, 3'd1, 3'd3, 8'd1, 7'd88});

        // Burn a chance, then reset while a press is in flight.
        step(1, 0, 0);
        check("fail_row1", '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0, 2'b01, 3'd1, 3'd2, 8'd1, 7'd88});
        step(0, 0, 1);
        step(1, 0, 1);
        check("inflight_press", '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 2'b01, 3'd2, 3'd2, 8'd2, 7'd72});
        #2 resetn = 1'b1;
        #1;
        check("midgame_reset", rst_vals);
        @(posedge clk);
        #1 resetn = 1'b0;
        step(1, 0, 1);
        check("post_reset_no_press", '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b01, 3'd0, 3'd3, 8'd0, 7'd104});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
